// File: rtl/nuc_pkg.sv
// Shared nucleotide encodings, pattern geometry and scanner state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nuc_pkg;

    typedef enum logic [1:0] {
        A = 2'b00,
        C = 2'b01,
        G = 2'b10,
        T = 2'b11
    } nuc_t;

    localparam int NUC_W   = 2;
    localparam int PAT_LEN = 4;
    localparam int PAT_W   = NUC_W * PAT_LEN;
    localparam int FILL_W  = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/nuc_window.sv
// Sliding nucleotide window with a saturating fill count; exposes the post-shift window.
// Latency: next_window/full_next are combinational from the current state and nuc.
// Backpressure: none; shifts whenever shift is high, clear wins over shift.
module nuc_window
    import nuc_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic [NUC_W-1:0] nuc,
    output logic [PAT_W-1:0] next_window,
    output logic             full_next
);

    logic [PAT_W-1:0]  window;
    logic [FILL_W-1:0] fill;

    assign next_window = {window[PAT_W-NUC_W-1:0], nuc};
    // The incoming nucleotide completes a full pattern once PAT_LEN-1 are already held.
    assign full_next   = (fill >= FILL_W'(PAT_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            window <= '0;
            fill   <= '0;
        end else if (shift) begin
            window <= next_window;
            if (fill != FILL_W'(PAT_LEN))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/nuc_pattern_scanner.sv
// Scans a nucleotide address range and counts 4-nucleotide pattern matches (NUC_OVERLAP_EN: count overlaps).
// Latency: start at cycle 0, one read per cycle over cycles 1..len, done pulses at cycle len+1.
// Backpressure: none; start is ignored unless IDLE, memory reads are single-cycle combinational.
module nuc_pattern_scanner
    import nuc_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      len,
    input  logic [PAT_W-1:0] pattern,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_re,
    input  logic [NUC_W-1:0] mem_data,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [AW:0]      match_count,
    output logic [AW-1:0]    first_match_addr
);

    scan_state_t      state_q, state_d;
    logic             accept;
    logic             fetching;
    logic             last;
    logic             hit;
    logic             win_clear;
    logic [AW-1:0]    addr_q;
    logic [AW:0]      remain_q;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] next_window;
    logic             full_next;

    assign fetching = (state_q == FETCH);
    assign last     = (remain_q == {{AW{1'b0}}, 1'b1});
    assign hit      = fetching && full_next && (next_window == pat_q);
    assign mem_addr = addr_q;

`ifdef NUC_OVERLAP_EN
    assign win_clear = accept;
`else
    // Restarting the fill after a hit forces the next match to begin past this one.
    assign win_clear = accept || hit;
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        mem_re  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_re = 1'b1;
                busy   = 1'b1;
                if (last)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q           <= '0;
            remain_q         <= '0;
            pat_q            <= '0;
            match_count      <= '0;
            found            <= 1'b0;
            first_match_addr <= '0;
        end else if (accept) begin
            addr_q           <= base_addr;
            remain_q         <= len;
            pat_q            <= pattern;
            match_count      <= '0;
            found            <= 1'b0;
            first_match_addr <= '0;
        end else if (fetching) begin
            addr_q   <= addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (hit) begin
                match_count <= match_count + 1'b1;
                if (!found) begin
                    found            <= 1'b1;
                    first_match_addr <= addr_q - AW'(PAT_LEN - 1);
                end
            end
        end
    end

    nuc_window u_window (
        .clock       (clock),
        .reset       (reset),
        .clear       (win_clear),
        .shift       (fetching),
        .nuc         (mem_data),
        .next_window (next_window),
        .full_next   (full_next)
    );

endmodule
